snake_row_scanner: RTL and testbench
====================================

# snake_row_scanner

Per-scanline occupancy scanner between the memory-mapped snake/food registers and the VGA pixel path. On a start strobe for grid row `r`, it walks the packed snake segment coordinate vectors one segment per clock. It produces 16-bit column masks for head, body and food in that row, plus a self-overlap flag. The pixel path then needs only a mask bit lookup per pixel, with no 100-way compare. It runs on the 25 MHz pixel clock and is kicked once per grid row during horizontal blanking (160 cycles available, at most 101 used).

## Interface
Parameters:
- `NUM_SEG`, 100: segment slots in each packed coordinate vector.
- `GRID_W`, 16: grid columns; mask width.
- `ROW_W`, 4: row index width (16 grid rows).

Ports:
- `clk`, in, 1: pixel clock (25 MHz); all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high; returns the block to IDLE with all outputs 0.
- `start`, in, 1: one-cycle request to scan row `row`; ignored unless IDLE.
- `row`, in, ROW_W: grid row to scan; sampled only with an accepted `start`.
- `x_values`, in, NUM_SEG*32: segment k X is at bits [32k +: 32]; 32'hFFFFFFFF marks an empty slot.
- `y_values`, in, NUM_SEG*32: segment k Y, same packing.
- `food_x`, in, 32: food column.
- `food_y`, in, 32: food row.
- `busy`, out, 1: high from accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse when the mask outputs have updated.
- `head_mask`, out, GRID_W: bit c set when segment 0 is at (c, row).
- `body_mask`, out, GRID_W: bit c set when any segment 1..NUM_SEG-1 is at (c, row).
- `food_mask`, out, GRID_W: bit c set when food is at (c, row).
- `overlap`, out, 1: two or more examined segments share one cell in this row.

## Operation
- State machine:
  - IDLE: on `start`, latch `row`, clear the working masks and overlap, set idx=0, go to SCAN.
  - SCAN: examine segment idx once per cycle.
  - DONE: register the outputs, pulse `done`, return to IDLE.
- Per SCAN cycle, with sx = x_values[32·idx +: 32] and sy = y_values[32·idx +: 32]:
  - Terminator: if sx == 32'hFFFFFFFF or sy == 32'hFFFFFFFF, go to DONE. Segments are contiguous from slot 0, so nothing after the terminator is examined.
  - Hit: if sy == latched row (full 32-bit compare, upper bits zero) and sx < GRID_W, take c = sx[3:0].
    - If working (head|body) bit c is already set, set overlap.
    - Then set bit c in the head mask if idx == 0, otherwise in the body mask.
  - Out of range: sx ≥ GRID_W or sy ≥ 2^ROW_W never hits and is not an error.
  - Advance: if idx == NUM_SEG-1, go to DONE; otherwise idx += 1.
- DONE:
  - food_mask = (food_y == row && food_x < GRID_W) ? (1 << food_x[3:0]) : 0.
  - Food is sampled in DONE, not at start.
  - head_mask, body_mask and overlap are copied from the working registers.
- Outputs hold their values until the next DONE or reset. They never change while busy.
- `start` while busy is dropped; there is no queueing.
- Coordinate inputs may change mid-scan. Each segment's value is taken on the cycle it is examined.

## Timing
- Reset: state IDLE, idx 0, busy 0, done 0, all masks 0, overlap 0.
- Let E0 be the edge that accepts `start`; busy rises after E0.
- Let m be the number of slots examined: terminator index + 1, or NUM_SEG if there is no terminator.
  - Edge Ek (k = 1..m) examines slot k-1.
  - At edge Em the state becomes DONE.
  - At edge Em+1 the outputs update, `done` is high for exactly the cycle after Em+1, and busy goes low.
- Start-to-done latency is m+1 cycles; worst case is 101 (NUM_SEG = 100).
- A new `start` is accepted in the same cycle `done` is high, since the state is IDLE then. This gives back-to-back throughput of one row per m+1 cycles.
- `reset` asserted during SCAN aborts the scan. The next cycle is IDLE with cleared outputs, and no `done` pulse is produced.

## Test plan
- **Reset:** assert reset with all coordinate vectors at -1, pulse start with row=3. Outputs are all 0 after reset. `done` follows 2 cycles after start (m=1) with all masks 0 and overlap 0.
- **Three-segment snake:** segments (5,3), (4,3), (4,4), then terminator; food (9,3). Start with row=3 gives head_mask=0x0020, body_mask=0x0010, food_mask=0x0200, overlap=0, and `done` 5 cycles after start. Row=4 gives body_mask=0x0010, head_mask=0, food_mask=0.
- **Self-overlap:** segments (2,7), (3,7), (2,7), then terminator, row=7. Result: head_mask=0x0004, body_mask=0x000C, overlap=1. The same snake scanned with row=6 gives overlap=0.
- **Full 100 slots with no terminator:** all segments at (15,0), row=0. Result: head_mask=0x8000, body_mask=0x8000, overlap=1, latency 101 cycles, busy high for exactly 101 cycles.
- **Range and collision cases:**
  - Segment at (16,2) or food at (3,20) produces no mask bit.
  - `start` pulsed mid-scan is ignored; the outputs reflect only the first request.
  - Start asserted on the `done` cycle is accepted.
- **Reset mid-scan:** assert reset at cycle 10 of a 50-segment scan. No `done` pulse, masks stay 0, busy is 0 the next cycle, and a fresh start then completes normally.

Source files
------------

// File: rtl/snake_row_scanner.sv
// Per-scanline occupancy scanner: walks the packed snake segment vectors for one
// grid row and produces head/body/food column masks plus a self-overlap flag.
module snake_row_scanner #(
  parameter int NUM_SEG = 100,
  parameter int GRID_W  = 16,
  parameter int ROW_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ROW_W-1:0]        row,
  input  logic [NUM_SEG*32-1:0]   x_values,
  input  logic [NUM_SEG*32-1:0]   y_values,
  input  logic [31:0]             food_x,
  input  logic [31:0]             food_y,
  output logic                    busy,
  output logic                    done,
  output logic [GRID_W-1:0]       head_mask,
  output logic [GRID_W-1:0]       body_mask,
  output logic [GRID_W-1:0]       food_mask,
  output logic                    overlap,
  output logic [1:0]              state_dbg
);

  localparam int IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // start is a request strobe only; it is accepted on a rising edge when the
  // state is IDLE and silently dropped otherwise (no ready/backpressure).
  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    idx;
  logic [ROW_W-1:0]    row_q;
  logic [GRID_W-1:0]   work_head;
  logic [GRID_W-1:0]   work_body;
  logic                work_ovl;

  logic [31:0]         seg_x;
  logic [31:0]         seg_y;
  logic [31:0]         row_ext;
  logic                seg_term;
  logic                seg_hit;
  logic [GRID_W-1:0]   seg_bit;
  logic                food_hit;
  logic [GRID_W-1:0]   food_bit;

  assign seg_x     = x_values[32*idx +: 32];
  assign seg_y     = y_values[32*idx +: 32];
  assign row_ext   = {{(32-ROW_W){1'b0}}, row_q};
  assign seg_term  = (seg_x == 32'hFFFF_FFFF) || (seg_y == 32'hFFFF_FFFF);
  assign seg_hit   = (seg_y == row_ext) && (seg_x < 32'(GRID_W));
  assign food_hit  = (food_y == row_ext) && (food_x < 32'(GRID_W));
  assign state_dbg = state;

  always_comb begin
    seg_bit = '0;
    seg_bit[seg_x[COL_W-1:0]] = 1'b1;
    food_bit = '0;
    food_bit[food_x[COL_W-1:0]] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (seg_term || idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      row_q     <= '0;
      work_head <= '0;
      work_body <= '0;
      work_ovl  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      head_mask <= '0;
      body_mask <= '0;
      food_mask <= '0;
      overlap   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_q     <= row;
            idx       <= '0;
            work_head <= '0;
            work_body <= '0;
            work_ovl  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (!seg_term) begin
            if (seg_hit) begin
              // Overlap is judged against cells marked before this segment.
              if (|((work_head | work_body) & seg_bit)) work_ovl <= 1'b1;
              if (idx == '0) work_head <= work_head | seg_bit;
              else           work_body <= work_body | seg_bit;
            end
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        DONE: begin
          head_mask <= work_head;
          body_mask <= work_body;
          overlap   <= work_ovl;
          food_mask <= food_hit ? food_bit : '0;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_row_scanner.sv
// Directed bench for snake_row_scanner: hand-computed masks, latencies and
// control behaviour for each scenario, ending in one summary line.
module tb_snake_row_scanner;

  localparam int NUM_SEG = 100;
  localparam int GRID_W  = 16;
  localparam int ROW_W   = 4;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [ROW_W-1:0]      row;
  logic [NUM_SEG*32-1:0] x_vec;
  logic [NUM_SEG*32-1:0] y_vec;
  logic [31:0]           food_x;
  logic [31:0]           food_y;
  logic                  busy;
  logic                  done;
  logic [GRID_W-1:0]     head_mask;
  logic [GRID_W-1:0]     body_mask;
  logic [GRID_W-1:0]     food_mask;
  logic                  overlap;
  logic [1:0]            state_dbg;

  int checks = 0;
  int errors = 0;
  int lat;
  int busy_cnt;

  snake_row_scanner #(.NUM_SEG(NUM_SEG), .GRID_W(GRID_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .reset(reset), .start(start), .row(row),
    .x_values(x_vec), .y_values(y_vec), .food_x(food_x), .food_y(food_y),
    .busy(busy), .done(done), .head_mask(head_mask), .body_mask(body_mask),
    .food_mask(food_mask), .overlap(overlap), .state_dbg(state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // driver tasks
  task automatic clear_segs();
    x_vec = '1;
    y_vec = '1;
  endtask

  task automatic set_seg(input int k, input logic [31:0] x, input logic [31:0] y);
    x_vec[32*k +: 32] = x;
    y_vec[32*k +: 32] = y;
  endtask

  // Pulses start for row r; lat counts edges after the accepting edge up to the
  // one after which done is seen; busy_cnt counts busy-high samples.
  task automatic do_scan(input int r, input int glitch_at, input int glitch_row);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    row   = ROW_W'(r);
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!seen && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else if (lat == glitch_at) begin
        start = 1'b1;
        row   = ROW_W'(glitch_row);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL scan_timeout row=%0d: done not seen within %0d cycles", r, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; row = '0;
    clear_segs();
    food_x = '1; food_y = '1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (head_mask !== 16'h0 || body_mask !== 16'h0 || food_mask !== 16'h0 || overlap !== 1'b0) begin errors++;
      $display("FAIL reset_masks h=%h b=%h f=%h o=%b exp 0", head_mask, body_mask, food_mask, overlap); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp 0", state_dbg); end
    do_scan(3, -1, 0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL empty_latency got=%0d exp 2", lat); end
    checks++; if (head_mask !== 16'h0 || body_mask !== 16'h0 || food_mask !== 16'h0 || overlap !== 1'b0) begin errors++;
      $display("FAIL empty_masks h=%h b=%h f=%h o=%b exp 0", head_mask, body_mask, food_mask, overlap); end
  endtask

  task automatic test_three_seg();
    clear_segs();
    set_seg(0, 5, 3); set_seg(1, 4, 3); set_seg(2, 4, 4);
    food_x = 9; food_y = 3;
    do_scan(3, -1, 0);
    checks++; if (lat !== 5) begin errors++; $display("FAIL three_latency got=%0d exp 5", lat); end
    checks++; if (head_mask !== 16'h0020 || body_mask !== 16'h0010) begin errors++;
      $display("FAIL three_row3 h=%h b=%h exp 0020 0010", head_mask, body_mask); end
    checks++; if (food_mask !== 16'h0200 || overlap !== 1'b0) begin errors++;
      $display("FAIL three_row3_food f=%h o=%b exp 0200 0", food_mask, overlap); end
    do_scan(4, -1, 0);
    checks++; if (head_mask !== 16'h0 || body_mask !== 16'h0010 || food_mask !== 16'h0) begin errors++;
      $display("FAIL three_row4 h=%h b=%h f=%h exp 0000 0010 0000", head_mask, body_mask, food_mask); end
  endtask

  task automatic test_overlap();
    clear_segs();
    set_seg(0, 2, 7); set_seg(1, 3, 7); set_seg(2, 2, 7);
    do_scan(7, -1, 0);
    checks++; if (head_mask !== 16'h0004 || body_mask !== 16'h000C || overlap !== 1'b1) begin errors++;
      $display("FAIL overlap_row7 h=%h b=%h o=%b exp 0004 000c 1", head_mask, body_mask, overlap); end
    do_scan(6, -1, 0);
    checks++; if (head_mask !== 16'h0 || body_mask !== 16'h0 || overlap !== 1'b0) begin errors++;
      $display("FAIL overlap_row6 h=%h b=%h o=%b exp 0 0 0", head_mask, body_mask, overlap); end
  endtask

  task automatic test_full();
    for (int k = 0; k < NUM_SEG; k++) set_seg(k, 15, 0);
    food_x = 0; food_y = 5;
    // Food moves mid-scan; only the value seen in DONE may count.
    fork
      do_scan(0, -1, 0);
      begin
        repeat (50) @(posedge clk);
        #2;
        food_x = 4; food_y = 0;
      end
    join
    checks++; if (lat !== 101) begin errors++; $display("FAIL full_latency got=%0d exp 101", lat); end
    checks++; if (busy_cnt !== 101) begin errors++; $display("FAIL full_busy got=%0d exp 101", busy_cnt); end
    checks++; if (head_mask !== 16'h8000 || body_mask !== 16'h8000 || overlap !== 1'b1) begin errors++;
      $display("FAIL full_masks h=%h b=%h o=%b exp 8000 8000 1", head_mask, body_mask, overlap); end
    checks++; if (food_mask !== 16'h0010) begin errors++; $display("FAIL full_food got=%h exp 0010", food_mask); end
  endtask

  task automatic test_range();
    clear_segs();
    set_seg(0, 16, 2); set_seg(1, 3, 2); set_seg(2, 6, 18); set_seg(3, 32'h0001_0001, 2);
    food_x = 3; food_y = 20;
    do_scan(2, -1, 0);
    checks++; if (head_mask !== 16'h0 || body_mask !== 16'h0008 || overlap !== 1'b0) begin errors++;
      $display("FAIL range_masks h=%h b=%h o=%b exp 0000 0008 0", head_mask, body_mask, overlap); end
    checks++; if (food_mask !== 16'h0) begin errors++; $display("FAIL range_food got=%h exp 0000", food_mask); end
    food_x = 3; food_y = 32'h1000_0002;
    do_scan(2, -1, 0);
    checks++; if (food_mask !== 16'h0) begin errors++; $display("FAIL range_food_hi got=%h exp 0000", food_mask); end
  endtask

  task automatic test_midscan_start();
    clear_segs();
    set_seg(0, 1, 5); set_seg(1, 2, 5); set_seg(2, 3, 5);
    food_x = 0; food_y = 0;
    do_scan(5, 2, 6);
    checks++; if (lat !== 5) begin errors++; $display("FAIL midstart_latency got=%0d exp 5", lat); end
    checks++; if (head_mask !== 16'h0002 || body_mask !== 16'h000C || food_mask !== 16'h0) begin errors++;
      $display("FAIL midstart_masks h=%h b=%h f=%h exp 0002 000c 0000", head_mask, body_mask, food_mask); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midstart_idle busy=%b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int n;
    clear_segs();
    set_seg(0, 5, 3); set_seg(1, 4, 3); set_seg(2, 4, 4);
    food_x = 9; food_y = 3;
    do_scan(3, -1, 0);
    checks++; if (head_mask !== 16'h0020 || body_mask !== 16'h0010) begin errors++;
      $display("FAIL b2b_first h=%h b=%h exp 0020 0010", head_mask, body_mask); end
    start = 1'b1;
    row   = 4'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b exp 1", busy); end
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    checks++; if (!seen || n !== 5) begin errors++; $display("FAIL b2b_latency got=%0d seen=%b exp 5", n, seen); end
    checks++; if (head_mask !== 16'h0 || body_mask !== 16'h0010 || food_mask !== 16'h0) begin errors++;
      $display("FAIL b2b_second h=%h b=%h f=%h exp 0000 0010 0000", head_mask, body_mask, food_mask); end
  endtask

  task automatic test_reset_midscan();
    bit seen;
    clear_segs();
    for (int k = 0; k < 50; k++) set_seg(k, 7, 1);
    food_x = 7; food_y = 1;
    @(negedge clk);
    start = 1'b1;
    row   = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin errors++;
      $display("FAIL abort_ctrl busy=%b done=%b state=%0d exp 0 0 0", busy, done, state_dbg); end
    checks++; if (head_mask !== 16'h0 || body_mask !== 16'h0 || food_mask !== 16'h0 || overlap !== 1'b0) begin errors++;
      $display("FAIL abort_masks h=%h b=%h f=%h o=%b exp 0", head_mask, body_mask, food_mask, overlap); end
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_done_pulse seen=%b exp 0", seen); end
    do_scan(1, -1, 0);
    checks++; if (lat !== 52) begin errors++; $display("FAIL restart_latency got=%0d exp 52", lat); end
    checks++; if (head_mask !== 16'h0080 || body_mask !== 16'h0080 || food_mask !== 16'h0080 || overlap !== 1'b1) begin errors++;
      $display("FAIL restart_masks h=%h b=%h f=%h o=%b exp 0080 0080 0080 1", head_mask, body_mask, food_mask, overlap); end
  endtask

  initial begin
    test_reset();
    test_three_seg();
    test_overlap();
    test_full();
    test_range();
    test_midscan_start();
    test_back_to_back();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
